// File: rtl/bounce_motion_if.sv
// Signal bundle between the bounce motion engine and its surroundings.
// The master side supplies vsync and the run enable. The slave side (the
// motion engine) returns the logo position, the direction flags and the
// event outputs that the pixel renderer uses.
interface bounce_motion_if;
    logic       vsync;
    logic       run;
    logic [9:0] obj_x;
    logic [9:0] obj_y;
    logic       dir_x;
    logic       dir_y;
    logic       hit_x;
    logic       hit_y;
    logic       corner;
    logic       bg_flash;
    logic [7:0] bounce_cnt;

    modport master (
        output vsync,
        output run,
        input  obj_x,
        input  obj_y,
        input  dir_x,
        input  dir_y,
        input  hit_x,
        input  hit_y,
        input  corner,
        input  bg_flash,
        input  bounce_cnt
    );

    modport slave (
        input  vsync,
        input  run,
        output obj_x,
        output obj_y,
        output dir_x,
        output dir_y,
        output hit_x,
        output hit_y,
        output corner,
        output bg_flash,
        output bounce_cnt
    );
endinterface

// File: rtl/bounce_motion_ctrl.sv
// Per-frame motion engine for the bouncing logo.
// A frame tick is taken from the leading edge of vsync. Every FRAME_DIV
// ticks the logo moves STEP pixels on each axis. It reflects off the padded
// screen edges. Each reflection produces a one-cycle hit or corner pulse,
// a background flash that lasts a fixed number of frames, and a saturating
// bounce count. Position changes only on move edges. The renderer therefore
// sees stable coordinates for the whole visible region.
module bounce_motion_ctrl #(
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int OBJ_W        = 93,
    parameter int OBJ_H        = 50,
    parameter int PAD          = 50,
    parameter int STEP         = 1,
    parameter int FRAME_DIV    = 2,
    parameter int FLASH_FRAMES = 8,
    parameter bit VS_POL       = 1'b0,
    parameter int X_INIT       = 50,
    parameter int Y_INIT       = 50
) (
    input  logic            clk,
    input  logic            rst_n,
    bounce_motion_if.slave  bus
);

    // Edge limits and step size. They are held in 11 bits so that
    // pos + STEP cannot wrap before it is compared with the limit.
    localparam logic [10:0] XMIN   = 11'(PAD);
    localparam logic [10:0] XMAX   = 11'(H_VISIBLE - PAD - OBJ_W);
    localparam logic [10:0] YMIN   = 11'(PAD);
    localparam logic [10:0] YMAX   = 11'(V_VISIBLE - PAD - OBJ_H);
    localparam logic [10:0] STEP11 = 11'(STEP);

    localparam int          DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [7:0]  FLASH_LOAD = 8'(FLASH_FRAMES);

    // Frame-tick detection
    logic             vs_q;
    logic             tick_q;
    logic             vs_active;

    // Motion state
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;

    // Event outputs
    logic             hit_x_q, hit_x_d;
    logic             hit_y_q, hit_y_d;
    logic             corner_q, corner_d;
    logic [7:0]       flash_q, flash_d;
    logic             bg_flash_q;
    logic [7:0]       cnt_q, cnt_d;

    // Intermediate move results
    logic             move;
    logic [12:0]      x_step, y_step;
    logic             any_hit;

    // Moves one axis by one step and reflects at the limits.
    // Returns {hit, new_dir, new_pos[10:0]}. If the step would reach or pass
    // an edge, the position clamps to that edge. The logo never goes past
    // an edge, and the position never underflows.
    function automatic logic [12:0] axis_step(
        input logic [10:0] pos,
        input logic        dir,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [12:0] r;
        if (dir) begin
            if (pos + STEP11 >= hi) r = {1'b1, 1'b0, hi};
            else                    r = {1'b0, 1'b1, pos + STEP11};
        end else begin
            if (pos <= lo + STEP11) r = {1'b1, 1'b1, lo};
            else                    r = {1'b0, 1'b0, pos - STEP11};
        end
        return r;
    endfunction

    assign vs_active = (bus.vsync == VS_POL);

    // Tick on the first cycle that vsync is seen active. After reset, vs_q
    // starts at the active level. A reset released during vsync then waits
    // for the next full vsync assertion before it ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= VS_POL;
            tick_q <= 1'b0;
        end else begin
            vs_q   <= bus.vsync;
            tick_q <= vs_active && (vs_q != VS_POL);
        end
    end

    // Next-state logic: prescaler, movement and reflection on each axis,
    // hit events, flash countdown and bounce count.
    always_comb begin
        move    = tick_q && bus.run && (div_q == DIV_LAST);
        x_step  = axis_step({1'b0, x_q}, dir_x_q, XMIN, XMAX);
        y_step  = axis_step({1'b0, y_q}, dir_y_q, YMIN, YMAX);

        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        hit_x_d = 1'b0;
        hit_y_d = 1'b0;

        // The prescaler only advances on ticks while running, so a pause
        // keeps the frame phase at which motion stopped.
        if (tick_q && bus.run) begin
            if (move) div_d = '0;
            else      div_d = div_q + 1'b1;
        end

        if (move) begin
            x_d     = x_step[9:0];
            dir_x_d = x_step[11];
            hit_x_d = x_step[12];
            y_d     = y_step[9:0];
            dir_y_d = y_step[11];
            hit_y_d = y_step[12];
        end

        any_hit  = hit_x_d || hit_y_d;
        corner_d = hit_x_d && hit_y_d;

        // Count a move once, even when both axes reflect, and stop at 255.
        cnt_d = cnt_q;
        if (any_hit && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;

        // A new hit reloads the flash counter, and the reload wins over the
        // countdown on the same edge. The countdown runs on every frame,
        // even while paused, so the flash always ends.
        flash_d = flash_q;
        if (any_hit)                          flash_d = FLASH_LOAD;
        else if (tick_q && (flash_q != 8'd0)) flash_d = flash_q - 8'd1;
    end

    // State registers. Reset asynchronously restores the power-up position
    // and clears every event output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            x_q        <= 10'(X_INIT);
            y_q        <= 10'(Y_INIT);
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            hit_x_q    <= 1'b0;
            hit_y_q    <= 1'b0;
            corner_q   <= 1'b0;
            flash_q    <= 8'd0;
            bg_flash_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            hit_x_q    <= hit_x_d;
            hit_y_q    <= hit_y_d;
            corner_q   <= corner_d;
            flash_q    <= flash_d;
            bg_flash_q <= (flash_d != 8'd0);
            cnt_q      <= cnt_d;
        end
    end

    assign bus.obj_x      = x_q;
    assign bus.obj_y      = y_q;
    assign bus.dir_x      = dir_x_q;
    assign bus.dir_y      = dir_y_q;
    assign bus.hit_x      = hit_x_q;
    assign bus.hit_y      = hit_y_q;
    assign bus.corner     = corner_q;
    assign bus.bg_flash   = bg_flash_q;
    assign bus.bounce_cnt = cnt_q;

endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// Directed testbench for bounce_motion_ctrl. Four instances run side by
// side, each with a different parameter set. They share clk, rst_n and
// vsync, and each scenario examines only the instance it is about.
`timescale 1ns/1ps
module tb_bounce_motion_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bounce_motion_if if0 ();
    bounce_motion_if if1 ();
    bounce_motion_if if2 ();
    bounce_motion_if if3 ();

    // Defaults: start (50,50), two frames per move
    bounce_motion_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    // One step from the right edge, one frame per move
    bounce_motion_ctrl #(.X_INIT(496), .Y_INIT(100), .FRAME_DIV(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    // One step from the bottom-right corner
    bounce_motion_ctrl #(.X_INIT(496), .Y_INIT(379), .FRAME_DIV(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    // Huge step: every move is a corner hit
    bounce_motion_ctrl #(.STEP(447), .FRAME_DIV(1))
        u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_vsync(input logic v);
        if0.vsync = v;
        if1.vsync = v;
        if2.vsync = v;
        if3.vsync = v;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One video frame: vsync (active-low) is held low for 4 clocks, then
    // high for 10 clocks.
    task automatic frame();
        @(negedge clk);
        set_vsync(1'b0);
        repeat (4) @(negedge clk);
        set_vsync(1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({if0.obj_x, if0.obj_y} !== {10'd50, 10'd50}) begin
            bad++;
            $display("FAIL reset_pos got=(%0d,%0d) exp=(50,50)", if0.obj_x, if0.obj_y);
        end
        total++;
        if ({if0.dir_x, if0.dir_y, if0.hit_x, if0.hit_y, if0.corner, if0.bg_flash} !== 6'b110000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=110000",
                     {if0.dir_x, if0.dir_y, if0.hit_x, if0.hit_y, if0.corner, if0.bg_flash});
        end
        total++;
        if (if0.bounce_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0", if0.bounce_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset: checked reset state");
    endtask

    task automatic test_default_motion();
        int exp_pos [4] = '{50, 51, 51, 52};
        apply_reset();
        for (int f = 0; f < 4; f++) begin
            frame();
            total++;
            if (if0.obj_x !== 10'(exp_pos[f]) || if0.obj_y !== 10'(exp_pos[f])) begin
                bad++;
                $display("FAIL default_move frame=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                         f + 1, if0.obj_x, if0.obj_y, exp_pos[f], exp_pos[f]);
            end
        end
        total++;
        if (if0.bounce_cnt !== 8'd0 || if0.bg_flash !== 1'b0) begin
            bad++;
            $display("FAIL default_nohit cnt=%0d flash=%b exp=0/0", if0.bounce_cnt, if0.bg_flash);
        end
        $display("test_default_motion: obj=(%0d,%0d)", if0.obj_x, if0.obj_y);
    endtask

    task automatic test_x_hit();
        apply_reset();
        @(negedge clk);
        set_vsync(1'b0);
        @(posedge clk);          // vsync first sampled active
        @(posedge clk);          // move edge
        #1;
        total++;
        if (if1.obj_x !== 10'd497 || if1.dir_x !== 1'b0 || if1.hit_x !== 1'b1) begin
            bad++;
            $display("FAIL xhit_move got x=%0d dir=%b hit=%b exp x=497 dir=0 hit=1",
                     if1.obj_x, if1.dir_x, if1.hit_x);
        end
        total++;
        if (if1.hit_y !== 1'b0 || if1.corner !== 1'b0 || if1.bounce_cnt !== 8'd1 || if1.bg_flash !== 1'b1) begin
            bad++;
            $display("FAIL xhit_side got hy=%b cor=%b cnt=%0d fl=%b exp 0/0/1/1",
                     if1.hit_y, if1.corner, if1.bounce_cnt, if1.bg_flash);
        end
        total++;
        if (if1.obj_y !== 10'd101) begin
            bad++;
            $display("FAIL xhit_y got=%0d exp=101", if1.obj_y);
        end
        @(posedge clk);
        #1;
        total++;
        if (if1.hit_x !== 1'b0) begin
            bad++;
            $display("FAIL xhit_pulse_width got=%b exp=0", if1.hit_x);
        end
        @(negedge clk);
        set_vsync(1'b1);
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            frame();
            total++;
            if (if1.bg_flash !== (k < 8)) begin
                bad++;
                $display("FAIL flash_len frame=%0d got=%b exp=%b", k, if1.bg_flash, (k < 8));
            end
        end
        total++;
        if (if1.obj_x !== 10'd489 || if1.bounce_cnt !== 8'd1) begin
            bad++;
            $display("FAIL xhit_after got x=%0d cnt=%0d exp x=489 cnt=1", if1.obj_x, if1.bounce_cnt);
        end
        $display("test_x_hit: x=%0d cnt=%0d", if1.obj_x, if1.bounce_cnt);
    endtask

    task automatic test_corner();
        apply_reset();
        @(negedge clk);
        set_vsync(1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if ({if2.obj_x, if2.obj_y} !== {10'd497, 10'd380} || {if2.dir_x, if2.dir_y} !== 2'b00) begin
            bad++;
            $display("FAIL corner_pos got=(%0d,%0d) dirs=%b%b exp=(497,380) dirs=00",
                     if2.obj_x, if2.obj_y, if2.dir_x, if2.dir_y);
        end
        total++;
        if ({if2.hit_x, if2.hit_y, if2.corner} !== 3'b111 || if2.bounce_cnt !== 8'd1) begin
            bad++;
            $display("FAIL corner_pulse got=%b cnt=%0d exp=111 cnt=1",
                     {if2.hit_x, if2.hit_y, if2.corner}, if2.bounce_cnt);
        end
        @(posedge clk);
        #1;
        total++;
        if (if2.corner !== 1'b0) begin
            bad++;
            $display("FAIL corner_width got=%b exp=0", if2.corner);
        end
        @(negedge clk);
        set_vsync(1'b1);
        repeat (10) @(negedge clk);
        $display("test_corner: obj=(%0d,%0d)", if2.obj_x, if2.obj_y);
    endtask

    task automatic test_run_pause();
        apply_reset();
        frame();                 // prescaler now at 1, no move yet
        if0.run = 1'b0;
        repeat (10) frame();
        total++;
        if ({if0.obj_x, if0.obj_y} !== {10'd50, 10'd50}) begin
            bad++;
            $display("FAIL pause_hold got=(%0d,%0d) exp=(50,50)", if0.obj_x, if0.obj_y);
        end
        if0.run = 1'b1;
        frame();                 // resumes at the stored phase: moves now
        total++;
        if ({if0.obj_x, if0.obj_y} !== {10'd51, 10'd51}) begin
            bad++;
            $display("FAIL pause_resume got=(%0d,%0d) exp=(51,51)", if0.obj_x, if0.obj_y);
        end
        $display("test_run_pause: obj=(%0d,%0d)", if0.obj_x, if0.obj_y);
    endtask

    task automatic test_reset_during_vsync();
        @(negedge clk);
        set_vsync(1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (if1.obj_x !== 10'd496 || if1.bounce_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rst_vsync_spurious got x=%0d cnt=%0d exp x=496 cnt=0",
                     if1.obj_x, if1.bounce_cnt);
        end
        set_vsync(1'b1);
        repeat (5) @(negedge clk);
        frame();
        total++;
        if (if1.obj_x !== 10'd497 || if0.obj_x !== 10'd50) begin
            bad++;
            $display("FAIL rst_vsync_first got u1x=%0d u0x=%0d exp 497/50", if1.obj_x, if0.obj_x);
        end
        frame();
        total++;
        if (if0.obj_x !== 10'd51) begin
            bad++;
            $display("FAIL rst_vsync_second got=%0d exp=51", if0.obj_x);
        end
        $display("test_reset_during_vsync: u0x=%0d u1x=%0d", if0.obj_x, if1.obj_x);
    endtask

    task automatic test_async_reset();
        apply_reset();
        frame();                 // u1 hits the right edge; flash active
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (if1.bg_flash !== 1'b0 || if1.obj_x !== 10'd496 || if1.dir_x !== 1'b1 || if1.bounce_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset got fl=%b x=%0d dir=%b cnt=%0d exp 0/496/1/0",
                     if1.bg_flash, if1.obj_x, if1.dir_x, if1.bounce_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_async_reset: state cleared");
    endtask

    task automatic test_saturate();
        logic [9:0] ex;
        int         ec;
        apply_reset();
        for (int f = 1; f <= 300; f++) begin
            frame();
            ex = (f % 2 == 1) ? 10'd497 : 10'd50;
            ec = (f > 255) ? 255 : f;
            total++;
            if (if3.obj_x !== ex) begin
                bad++;
                $display("FAIL sat_x frame=%0d got=%0d exp=%0d", f, if3.obj_x, ex);
            end
            total++;
            if (if3.bounce_cnt !== 8'(ec)) begin
                bad++;
                $display("FAIL sat_cnt frame=%0d got=%0d exp=%0d", f, if3.bounce_cnt, ec);
            end
        end
        $display("test_saturate: x=%0d cnt=%0d", if3.obj_x, if3.bounce_cnt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_vsync(1'b1);
        if0.run = 1'b1;
        if1.run = 1'b1;
        if2.run = 1'b1;
        if3.run = 1'b1;
        test_reset();
        test_default_motion();
        test_x_hit();
        test_corner();
        test_run_pause();
        test_reset_during_vsync();
        test_async_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
